// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with operand forwarding and load-use detection.
//
// Captures the decode-stage instruction into the execute stage on each rising
// edge of clk_i. Holds on stall_i, inserts a bubble on flush_i (flush wins
// over stall), and resets to the bubble state on rst_i (synchronous,
// active-high, highest priority).
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   stall_i, flush_i              hold / bubble requests from hazard control
//   id_*                          decode-stage qualifiers, data and indices
//   mem_*, wb_*                   forwarding sources from MEM and WB stages
//   ex_op_a_o, ex_op_b_o          execute operands (forwarded, imm-muxed)
//   ex_store_data_o               forwarded rs2 for stores
//   ex_pc_o, ex_valid_o,
//   ex_reg_we_o, ex_is_load_o,
//   ex_rd_addr_o, ex_logic_op_o   registered execute-stage control
//   load_use_o                    load-use hazard request
module id_ex_reg #(
  parameter logic [31:0] RESET_PC        = 32'h0,
  parameter logic [1:0]  BUBBLE_LOGIC_OP = 2'b00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        id_valid_i,
  input  logic        id_reg_we_i,
  input  logic        id_use_imm_i,
  input  logic        id_is_load_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_rs1_data_i,
  input  logic [31:0] id_rs2_data_i,
  input  logic [31:0] id_imm_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic [1:0]  id_logic_op_i,
  input  logic        mem_reg_we_i,
  input  logic        wb_reg_we_i,
  input  logic [4:0]  mem_rd_addr_i,
  input  logic [4:0]  wb_rd_addr_i,
  input  logic [31:0] mem_result_i,
  input  logic [31:0] wb_result_i,
  output logic [31:0] ex_op_a_o,
  output logic [31:0] ex_op_b_o,
  output logic [31:0] ex_store_data_o,
  output logic [31:0] ex_pc_o,
  output logic        ex_valid_o,
  output logic        ex_reg_we_o,
  output logic        ex_is_load_o,
  output logic [4:0]  ex_rd_addr_o,
  output logic [1:0]  ex_logic_op_o,
  output logic        load_use_o
);

  logic        valid_q;
  logic        reg_we_q;
  logic        use_imm_q;
  logic        is_load_q;
  logic [31:0] pc_q;
  logic [31:0] rs1_data_q;
  logic [31:0] rs2_data_q;
  logic [31:0] imm_q;
  logic [4:0]  rs1_addr_q;
  logic [4:0]  rs2_addr_q;
  logic [4:0]  rd_addr_q;
  logic [1:0]  logic_op_q;

  logic [31:0] rs1_fwd;
  logic [31:0] rs2_fwd;

  // MEM is younger than WB, so it takes priority; x0 never forwards.
  always_comb begin
    rs1_fwd = rs1_data_q;
    if (mem_reg_we_i && (rs1_addr_q != '0) && (mem_rd_addr_i == rs1_addr_q))
      rs1_fwd = mem_result_i;
    else if (wb_reg_we_i && (rs1_addr_q != '0) && (wb_rd_addr_i == rs1_addr_q))
      rs1_fwd = wb_result_i;
  end

  always_comb begin
    rs2_fwd = rs2_data_q;
    if (mem_reg_we_i && (rs2_addr_q != '0) && (mem_rd_addr_i == rs2_addr_q))
      rs2_fwd = mem_result_i;
    else if (wb_reg_we_i && (rs2_addr_q != '0) && (wb_rd_addr_i == rs2_addr_q))
      rs2_fwd = wb_result_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      valid_q    <= 1'b0;
      reg_we_q   <= 1'b0;
      use_imm_q  <= 1'b0;
      is_load_q  <= 1'b0;
      pc_q       <= RESET_PC;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      logic_op_q <= BUBBLE_LOGIC_OP;
    end else if (stall_i) begin
      // Refresh operand data while held so a result retiring from WB during
      // the stall is not lost once it leaves the forwarding window.
      rs1_data_q <= rs1_fwd;
      rs2_data_q <= rs2_fwd;
    end else begin
      valid_q    <= id_valid_i;
      reg_we_q   <= id_reg_we_i & id_valid_i;
      use_imm_q  <= id_use_imm_i;
      is_load_q  <= id_is_load_i & id_valid_i;
      pc_q       <= id_pc_i;
      rs1_data_q <= id_rs1_data_i;
      rs2_data_q <= id_rs2_data_i;
      imm_q      <= id_imm_i;
      rs1_addr_q <= id_rs1_addr_i;
      rs2_addr_q <= id_rs2_addr_i;
      rd_addr_q  <= id_rd_addr_i;
      logic_op_q <= id_logic_op_i;
    end
  end

  assign ex_op_a_o       = rs1_fwd;
  assign ex_op_b_o       = use_imm_q ? imm_q : rs2_fwd;
  assign ex_store_data_o = rs2_fwd;
  assign ex_pc_o         = pc_q;
  assign ex_valid_o      = valid_q;
  assign ex_reg_we_o     = reg_we_q;
  assign ex_is_load_o    = is_load_q;
  assign ex_rd_addr_o    = rd_addr_q;
  assign ex_logic_op_o   = logic_op_q;

  assign load_use_o = valid_q && is_load_q && (rd_addr_q != '0) && id_valid_i &&
                      ((rd_addr_q == id_rs1_addr_i) ||
                       ((rd_addr_q == id_rs2_addr_i) && !id_use_imm_i));

endmodule
